inv_keyexpansion: RTL and testbench

INV_KEYEXPANSION -- requirements
Module: inv_keyexpansion

---
 rtl/inv_keyexpansion.sv | 148 ++++++++++++++
 tb/tb_inv_keyexpansion.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_keyexpansion.sv
// AES-128 key schedule producing round keys in decryption order.
// Runs the forward schedule once, then walks back one key per request.
module inv_keyexpansion (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key,
    input  logic         start,
    input  logic         next,
    output logic [127:0] roundkey,
    output logic [3:0]   round,
    output logic         key_valid,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        READY
    } state_t;

    state_t state;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at bit offset 8*(255-x), which is 8*~x.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        unique case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p1, p2, p3;
    logic [31:0]  sub_in, sub_out, t;
    logic [3:0]   rc_idx;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] fwd_key, inv_key;

    assign w0 = roundkey[127:96];
    assign w1 = roundkey[95:64];
    assign w2 = roundkey[63:32];
    assign w3 = roundkey[31:0];

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    // One SubWord unit shared by both directions.
    assign sub_in = (state == FWD) ? {w3[23:0], w3[31:24]}
                                   : {p3[23:0], p3[31:24]};
    assign rc_idx = (state == FWD) ? round + 4'd1 : round;

    assign sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                      sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
    assign t = sub_out ^ {rcon(rc_idx), 24'h0};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign fwd_key = {n0, n1, n2, n3};
    assign inv_key = {w0 ^ t, p1, p2, p3};

    // Schedule FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            roundkey  <= '0;
            round     <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        roundkey  <= key;
                        round     <= '0;
                        key_valid <= 1'b0;
                        busy      <= 1'b1;
                        state     <= FWD;
                    end
                end
                FWD: begin
                    roundkey <= fwd_key;
                    round    <= round + 4'd1;
                    if (round == 4'd9) begin
                        key_valid <= 1'b1;
                        state     <= READY;
                    end
                end
                READY: begin
                    if (next) begin
                        if (round != 4'd0) begin
                            roundkey <= inv_key;
                            round    <= round - 4'd1;
                        end else begin
                            key_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    key_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_keyexpansion.sv
// Bench for inv_keyexpansion: FIPS-197 vectors plus an
// independent key-schedule model using a computed S-box.
module tb_inv_keyexpansion;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key;
    logic         start;
    logic         next;
    logic [127:0] roundkey;
    logic [3:0]   round;
    logic         key_valid;
    logic         busy;

    always #5 clk = ~clk;

    inv_keyexpansion dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .start     (start),
        .next      (next),
        .roundkey  (roundkey),
        .round     (round),
        .key_valid (key_valid),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] rk;
    } vec_t;

    localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    vec_t         tbl [11];
    logic [7:0]   sb [256];
    logic [127:0] mrk [11];
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_kv(input int budget);
        int n;
        n = 0;
        while (key_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("kv_timeout", {127'd0, key_valid}, 128'd1);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, x;
        for (int v = 0; v < 256; v++) begin
            x = v[7:0];
            inv = 8'h01;
            if (x == 8'h00) inv = 8'h00;
            else for (int k = 0; k < 254; k++) inv = gmul(inv, x);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[v] = s;
        end
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        w[0] = k[127:96];
        w[1] = k[95:64];
        w[2] = k[63:32];
        w[3] = k[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    initial begin
        int er;
        bit done;

        tbl[0]  = '{4'd0,  K1};
        tbl[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        tbl[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        tbl[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        tbl[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        tbl[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        tbl[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        tbl[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        tbl[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        tbl[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        build_sbox();

        rst = 1'b1;
        start = 1'b1;
        next = 1'b1;
        key = K1;
        step();
        step();
        chk("rst_roundkey", roundkey, 128'd0);
        chk("rst_round", {124'd0, round}, 128'd0);
        chk("rst_kv", {127'd0, key_valid}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);

        rst = 1'b0;
        next = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        key = ~K1;
        chk("acc_busy", {127'd0, busy}, 128'd1);
        chk("acc_kv", {127'd0, key_valid}, 128'd0);
        chk("acc_round", {124'd0, round}, 128'd0);

        for (int i = 1; i <= 9; i++) begin
            start = i[0];
            next = ~i[0];
            step();
            chk("fwd_round", {124'd0, round}, i);
            chk("fwd_kv", {127'd0, key_valid}, 128'd0);
        end
        start = 1'b0;
        next = 1'b0;
        step();
        chk("r10_kv", {127'd0, key_valid}, 128'd1);
        chk("r10_round", {124'd0, round}, 128'd10);
        chk("r10_key", roundkey, tbl[10].rk);
        chk("r10_busy", {127'd0, busy}, 128'd1);

        start = 1'b1;
        key = K2;
        repeat (5) step();
        chk("hold_round", {124'd0, round}, 128'd10);
        chk("hold_key", roundkey, tbl[10].rk);
        chk("hold_kv", {127'd0, key_valid}, 128'd1);

        next = 1'b1;
        for (int i = 9; i >= 0; i--) begin
            start = (i % 3 == 0);
            step();
            chk("walk_round", {124'd0, round}, {124'd0, tbl[i].rnd});
            chk("walk_key", roundkey, tbl[i].rk);
            chk("walk_kv", {127'd0, key_valid}, 128'd1);
        end

        start = 1'b1;
        key = K1;
        step();
        chk("end_kv", {127'd0, key_valid}, 128'd0);
        chk("end_busy", {127'd0, busy}, 128'd0);
        chk("end_key", roundkey, tbl[0].rk);
        next = 1'b0;
        step();
        start = 1'b0;
        chk("reacc_busy", {127'd0, busy}, 128'd1);
        chk("reacc_round", {124'd0, round}, 128'd0);

        wait_kv(12);
        next = 1'b1;
        repeat (4) step();
        next = 1'b0;
        chk("stall_at6", {124'd0, round}, 128'd6);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("stall_round", {124'd0, round}, 128'd6);
            chk("stall_key", roundkey, tbl[6].rk);
        end
        next = 1'b1;
        step();
        next = 1'b0;
        chk("resume_round", {124'd0, round}, 128'd5);
        chk("resume_key", roundkey, tbl[5].rk);

        rst = 1'b1;
        step();
        rst = 1'b0;
        key = K1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("mid_round", {124'd0, round}, 128'd5);
        rst = 1'b1;
        start = 1'b1;
        next = 1'b1;
        step();
        chk("abort_key", roundkey, 128'd0);
        chk("abort_round", {124'd0, round}, 128'd0);
        chk("abort_busy", {127'd0, busy}, 128'd0);
        chk("abort_kv", {127'd0, key_valid}, 128'd0);
        rst = 1'b0;
        next = 1'b0;
        key = K2;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("k2_kv", {127'd0, key_valid}, 128'd1);
        chk("k2_round", {124'd0, round}, 128'd10);
        chk("k2_r10", roundkey, K2R10);
        expand(K2);
        next = 1'b1;
        for (int i = 9; i >= 0; i--) begin
            step();
            chk("k2_walk_round", {124'd0, round}, i);
            chk("k2_walk_key", roundkey, mrk[i]);
        end
        step();
        next = 1'b0;
        chk("k2_idle_busy", {127'd0, busy}, 128'd0);

        for (int k = 0; k < 4; k++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            expand(key);
            start = 1'b1;
            step();
            start = 1'b0;
            key = {$urandom, $urandom, $urandom, $urandom};
            wait_kv(12);
            chk("rnd_r10", roundkey, mrk[10]);
            er = 10;
            done = 1'b0;
            for (int c = 0; c < 200 && !done; c++) begin
                next = ($urandom_range(0, 3) == 0);
                step();
                if (next) begin
                    if (er == 0) begin
                        done = 1'b1;
                        chk("rnd_idle_kv", {127'd0, key_valid}, 128'd0);
                        chk("rnd_idle_busy", {127'd0, busy}, 128'd0);
                    end else begin
                        er--;
                    end
                end
                if (!done) begin
                    chk("rnd_round", {124'd0, round}, er);
                    chk("rnd_key", roundkey, mrk[er]);
                end
            end
            next = 1'b0;
            if (!done) begin
                chk("rnd_timeout", {127'd0, done}, 128'd1);
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
